// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mult_pkg;

    localparam int MULT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_dp.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers, adder and shifters.
// MULT_EARLY_DONE_EN enables the early_last flag (remaining multiplier bits all zero).
module shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               early_last
);

    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic               early_last_s;

    // Conditional add of the shifted multiplicand; wraps mod 2^(2*WIDTH).
    always_comb begin
        acc_nxt_s = acc_r;
        if (mplier_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Termination hint: no set bits remain above the one consumed this cycle.
    always_comb begin
        early_last_s = 1'b0;
`ifdef MULT_EARLY_DONE_EN
        early_last_s = (mplier_r[WIDTH-1:1] == '0);
`else
        early_last_s = 1'b0;
`endif
    end

    // Operand capture on load, one shift-add step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
        end else if (load) begin
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= '0;
        end else if (step) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_nxt_s;
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end

    assign acc_nxt    = acc_nxt_s;
    assign early_last = early_last_s;

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-add multiplier: FSM, step counter and result register.
// Define MULT_EARLY_DONE_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] product_r;
    logic               load_s;
    logic               step_s;
    logic               last_step_s;
    logic               enter_done_s;
    logic               early_last_s;
    logic [2*WIDTH-1:0] acc_nxt_s;

    shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .step       (step_s),
        .a          (a),
        .b          (b),
        .acc_nxt    (acc_nxt_s),
        .early_last (early_last_s)
    );

    // Final CALC step: counter exhausted, or (optionally) nothing left to add.
    always_comb begin
        last_step_s = (cnt_r == CNT_W'(WIDTH - 1)) || early_last_s;
    end

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt_s  = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        enter_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CALC;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (last_step_s) begin
                    state_nxt_s  = DONE;
                    enter_done_s = 1'b1;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = CALC;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; product only updates on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == CALC);
            done_r  <= enter_done_s;
            if (load_s) begin
                cnt_r <= '0;
            end else if (step_s) begin
                cnt_r <= cnt_r + 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (enter_done_s) begin
                product_r <= acc_nxt_s;
            end else begin
                product_r <= product_r;
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a multiplication.
REQ-005 SHALL have port a  input  WIDTH  multiplicand, unsigned, sampled at start acceptance.
REQ-006 SHALL have port b  input  WIDTH  multiplier, unsigned, sampled at start acceptance.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking a valid new result.
REQ-009 SHALL have port product  output  2*WIDTH  registered result a*b.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored with no side effects.
REQ-012 On acceptance: mcand <= zero-extended a (2*WIDTH), mplier <= b, acc <= 0, cnt <= 0, state -> CALC.
REQ-013 Each CALC cycle: if mplier[0], acc <= acc + mcand (mod 2^(2*WIDTH)); mcand <<= 1; mplier >>= 1; cnt++.
REQ-014 CALC -> DONE after the cycle in which cnt reaches WIDTH-1 (exactly WIDTH CALC cycles when the feature in REQ-023 is off).
REQ-015 On entry to DONE: product <= final acc; done = 1 for exactly that one cycle; DONE -> IDLE next cycle unless start is accepted (then -> CALC).
REQ-016 Latency: start sampled at edge k gives done high during the cycle after edge k+WIDTH (WIDTH+1 cycles).
REQ-017 busy = 1 exactly while state is CALC; busy and done SHALL never be high together.
REQ-018 product SHALL hold its value from DONE entry until the next DONE entry; it SHALL NOT change during CALC.
REQ-019 Changes on a/b after acceptance SHALL NOT affect the running result.
REQ-020 b = 0 or a = 0 SHALL yield product 0 with normal done timing.

Reset
REQ-021 rst = 1 at a rising edge: state <= IDLE; busy, done, product, acc, mcand, mplier, cnt <= 0.
REQ-022 rst during CALC or DONE SHALL abort the operation with no done pulse; start is ignored while rst = 1.

Configuration
REQ-023 Macro MULT_EARLY_DONE_EN defined: CALC -> DONE also when (mplier >> 1) == 0 in the current CALC cycle; CALC cycle count = max(1, msb_index(b)+1); result identical.
REQ-024 Macro undefined: always WIDTH CALC cycles, per REQ-014/REQ-016.

Structure
REQ-025 Package mult_pkg SHALL hold the FSM state enum typedef (state_t) and the default width constant MULT_WIDTH_DEF = 8.
REQ-026 Datapath (mcand/mplier/acc registers, adder, shifters) SHALL be sub-module shift_add_dp; the FSM and counter stay in shift_add_mult_ctrl.

Verification
REQ-027 rst = 1 for 2 cycles -> busy = 0, done = 0, product = 0.
REQ-028 WIDTH = 8, a = 13, b = 11, start 1 cycle -> busy high 8 cycles, done pulse at cycle 9, product = 143.
REQ-029 a = 255, b = 255 -> product = 65025; then back-to-back start in DONE cycle with a = 3, b = 4 -> product = 12 after 9 more cycles.
REQ-030 a = 6, b = 7 accepted, start with a = 2, b = 3 during CALC -> ignored, single done, product = 42.
REQ-031 rst pulse at CALC cycle 4 -> no done, product stays at prior value (0 after reset); next a = 7, b = 6 -> 42.
REQ-032 a = 200, b = 1: with MULT_EARLY_DONE_EN done 2 cycles after start edge, without it 9; product = 200 in both cases; b = 0 -> product = 0.
